// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// States, opcodes and datapath select codes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_IMMEX    = 4'd10,
    S_LUIEX    = 4'd11,
    S_IMMWB    = 4'd12,
    S_JUMP     = 4'd13,
    S_JR       = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;
  localparam logic [1:0] ALUOP_LUI = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                      OP_ADDI, OP_J, OP_LUI};
  endfunction

endpackage

// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Outputs decode from state, qualified by mem_ready in memory states.
module mips_multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  state_t          state;
  state_t          nxt;
  logic [TO_W-1:0] to_cnt;
  logic            mem_st;
  logic            timeout;

  assign mem_st = (state == S_FETCH) ||
                  (state == S_MEMREAD) ||
                  (state == S_MEMWRITE);

  // mem_ready in the same cycle beats the timeout
  assign timeout = mem_st && !mem_ready &&
                   (to_cnt == TO_W'(MEM_TIMEOUT - 1));

  assign state_dbg = state;

  // Next-state selection
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (Opcode)
          OP_RTYPE: nxt = (Function == FUNCT_JR) ? S_JR : S_EXECUTE;
          OP_LW,
          OP_SW:    nxt = S_MEMADR;
          OP_BEQ:   nxt = S_BRANCH;
          OP_ADDI:  nxt = S_IMMEX;
          OP_LUI:   nxt = S_LUIEX;
          OP_J:     nxt = S_JUMP;
          default:  nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   nxt = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    nxt = S_MEMWB;
        else if (timeout) nxt = S_FETCH;
      end
      S_MEMWRITE: if (mem_ready || timeout) nxt = S_FETCH;
      S_EXECUTE:  nxt = S_ALUWB;
      S_IMMEX,
      S_LUIEX:    nxt = S_IMMWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_IMMWB,
      S_JUMP,
      S_JR:       nxt = S_FETCH;
      default:    nxt = S_IDLE;
    endcase
  end

  // State register and wait counter; a timed-out FETCH re-enters
  // itself, so the counter also clears on timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      to_cnt <= '0;
    end else begin
      state <= nxt;
      if (nxt != state || timeout)
        to_cnt <= '0;
      else if (mem_st && !mem_ready)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    ALUOp      = ALUOP_ADD;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        bus_err = timeout;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMMSH;
        illegal_op = !is_legal_op(Opcode);
        instr_done = !is_legal_op(Opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        IorD       = 1'b1;
        bus_err    = timeout;
        instr_done = timeout;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        bus_err    = timeout;
        instr_done = mem_ready || timeout;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FN;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_SUB;
        Branch     = 1'b1;
        PCSrc      = PCSRC_ALUOUT;
        instr_done = 1'b1;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_LUIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_LUI;
      end
      S_IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSrc      = PCSRC_RS;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multi-cycle MIPS controller.
// Expected state and control vectors per cycle are hand-written.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Opcode = '0;
  logic [5:0] Function = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegDst, MemtoReg, RegWrite;
  logic       instr_done, illegal_op, bus_err;
  logic [3:0] state_dbg;
  logic [18:0] ctl;

  int total = 0;
  int bad = 0;

  mips_multicycle_controller #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Function(Function),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .bus_err(bus_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ctl = {mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch,
                PCSrc, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg,
                RegWrite, instr_done, illegal_op, bus_err};

  localparam logic [3:0] ST_I = 4'd0, ST_F = 4'd1, ST_D = 4'd2;
  localparam logic [3:0] ST_MA = 4'd3, ST_MR = 4'd4, ST_MWB = 4'd5;
  localparam logic [3:0] ST_MW = 4'd6, ST_EX = 4'd7, ST_AWB = 4'd8;
  localparam logic [3:0] ST_BR = 4'd9, ST_IX = 4'd10, ST_LX = 4'd11;
  localparam logic [3:0] ST_IWB = 4'd12, ST_J = 4'd13, ST_JR = 4'd14;

  localparam logic [18:0] M_REQ  = 19'd1 << 18;
  localparam logic [18:0] M_IORD = 19'd1 << 17;
  localparam logic [18:0] M_MW   = 19'd1 << 16;
  localparam logic [18:0] M_IRW  = 19'd1 << 15;
  localparam logic [18:0] M_PCW  = 19'd1 << 14;
  localparam logic [18:0] M_BR   = 19'd1 << 13;
  localparam logic [18:0] PC_AO  = 19'd1 << 11;
  localparam logic [18:0] PC_JMP = 19'd2 << 11;
  localparam logic [18:0] PC_RS  = 19'd3 << 11;
  localparam logic [18:0] M_SRCA = 19'd1 << 10;
  localparam logic [18:0] SB_4   = 19'd1 << 8;
  localparam logic [18:0] SB_IMM = 19'd2 << 8;
  localparam logic [18:0] SB_SH  = 19'd3 << 8;
  localparam logic [18:0] AO_SUB = 19'd1 << 6;
  localparam logic [18:0] AO_FN  = 19'd2 << 6;
  localparam logic [18:0] AO_LUI = 19'd3 << 6;
  localparam logic [18:0] M_RD   = 19'd1 << 5;
  localparam logic [18:0] M_M2R  = 19'd1 << 4;
  localparam logic [18:0] M_RW   = 19'd1 << 3;
  localparam logic [18:0] M_DONE = 19'd1 << 2;
  localparam logic [18:0] M_ILL  = 19'd1 << 1;
  localparam logic [18:0] M_BUS  = 19'd1;

  localparam logic [18:0] E_FW  = M_REQ | SB_4;
  localparam logic [18:0] E_FR  = E_FW | M_IRW | M_PCW;
  localparam logic [18:0] E_FTO = E_FW | M_BUS;
  localparam logic [18:0] E_DEC = SB_SH;
  localparam logic [18:0] E_ILL = SB_SH | M_DONE | M_ILL;
  localparam logic [18:0] E_MA  = M_SRCA | SB_IMM;
  localparam logic [18:0] E_MR  = M_REQ | M_IORD;
  localparam logic [18:0] E_MWB = M_RW | M_M2R | M_DONE;
  localparam logic [18:0] E_WW  = M_REQ | M_IORD | M_MW;
  localparam logic [18:0] E_WR  = E_WW | M_DONE;
  localparam logic [18:0] E_WTO = E_WR | M_BUS;
  localparam logic [18:0] E_EX  = M_SRCA | AO_FN;
  localparam logic [18:0] E_AWB = M_RD | M_RW | M_DONE;
  localparam logic [18:0] E_BR  = M_SRCA | AO_SUB | M_BR | PC_AO | M_DONE;
  localparam logic [18:0] E_IX  = M_SRCA | SB_IMM;
  localparam logic [18:0] E_LX  = E_IX | AO_LUI;
  localparam logic [18:0] E_IWB = M_RW | M_DONE;
  localparam logic [18:0] E_J   = M_PCW | PC_JMP | M_DONE;
  localparam logic [18:0] E_JR  = M_PCW | PC_RS | M_DONE;

  initial begin
    #50000;
    $display("FAIL watchdog: sim time limit hit, total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++;
    if (state_dbg !== ST_I || ctl !== 19'd0) begin
      bad++;
      $display("FAIL reset_async: state=%0d ctl=%05h want 0/00000",
               state_dbg, ctl);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if (state_dbg !== ST_I || ctl !== 19'd0) begin
      bad++;
      $display("FAIL reset_idle: state=%0d ctl=%05h want 0/00000",
               state_dbg, ctl);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw();
    logic [3:0]  st [9];
    logic [18:0] ex [9];
    logic        rd [9];
    int          dones;
    st = '{ST_F, ST_F, ST_F, ST_D, ST_MA, ST_MR, ST_MR, ST_MR, ST_MWB};
    ex = '{E_FW, E_FW, E_FR, E_DEC, E_MA, E_MR, E_MR, E_MR, E_MWB};
    rd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dones = 0;
    Opcode = 6'b100011;
    Function = 6'b000000;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      #1;
      dones += int'(instr_done);
      total++;
      if (state_dbg !== st[i] || ctl !== ex[i]) begin
        bad++;
        $display("FAIL lw[%0d]: state=%0d ctl=%05h want %0d/%05h",
                 i, state_dbg, ctl, st[i], ex[i]);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL lw_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_rtype_jr();
    logic [3:0]  st [7];
    logic [18:0] ex [7];
    logic [5:0]  fn [7];
    logic        rd [7];
    st = '{ST_F, ST_D, ST_EX, ST_AWB, ST_F, ST_D, ST_JR};
    ex = '{E_FR, E_DEC, E_EX, E_AWB, E_FR, E_DEC, E_JR};
    fn = '{6'b100000, 6'b100000, 6'b100000, 6'b100000,
           6'b001000, 6'b001000, 6'b001000};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    Opcode = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      Function = fn[i];
      mem_ready = rd[i];
      #1;
      total++;
      if (state_dbg !== st[i] || ctl !== ex[i]) begin
        bad++;
        $display("FAIL rtype_jr[%0d]: state=%0d ctl=%05h want %0d/%05h",
                 i, state_dbg, ctl, st[i], ex[i]);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  st [14];
    logic [18:0] ex [14];
    logic [5:0]  op [14];
    logic        rd [14];
    st = '{ST_F, ST_D, ST_BR, ST_F, ST_D, ST_J,
           ST_F, ST_D, ST_IX, ST_IWB, ST_F, ST_D, ST_LX, ST_IWB};
    ex = '{E_FR, E_DEC, E_BR, E_FR, E_DEC, E_J,
           E_FR, E_DEC, E_IX, E_IWB, E_FR, E_DEC, E_LX, E_IWB};
    op = '{6'b000100, 6'b000100, 6'b000100,
           6'b000010, 6'b000010, 6'b000010,
           6'b001000, 6'b001000, 6'b001000, 6'b001000,
           6'b001111, 6'b001111, 6'b001111, 6'b001111};
    rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    Function = 6'b000000;
    for (int i = 0; i < 14; i++) begin
      Opcode = op[i];
      mem_ready = rd[i];
      #1;
      total++;
      if (state_dbg !== st[i] || ctl !== ex[i]) begin
        bad++;
        $display("FAIL b2b[%0d]: state=%0d ctl=%05h want %0d/%05h",
                 i, state_dbg, ctl, st[i], ex[i]);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [3:0]  st [3];
    logic [18:0] ex [3];
    logic        rd [3];
    st = '{ST_F, ST_D, ST_F};
    ex = '{E_FR, E_ILL, E_FW};
    rd = '{1'b1, 1'b0, 1'b0};
    Opcode = 6'b111111;
    Function = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rd[i];
      #1;
      total++;
      if (state_dbg !== st[i] || ctl !== ex[i]) begin
        bad++;
        $display("FAIL illegal[%0d]: state=%0d ctl=%05h want %0d/%05h",
                 i, state_dbg, ctl, st[i], ex[i]);
      end
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [3:0]  st [7];
    logic [18:0] ex [7];
    logic        rd [7];
    st = '{ST_F, ST_F, ST_F, ST_F, ST_F, ST_D, ST_J};
    ex = '{E_FW, E_FW, E_FW, E_FTO, E_FR, E_DEC, E_J};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (i == 4) Opcode = 6'b000010;
      mem_ready = rd[i];
      #1;
      total++;
      if (state_dbg !== st[i] || ctl !== ex[i]) begin
        bad++;
        $display("FAIL fetch_to[%0d]: state=%0d ctl=%05h want %0d/%05h",
                 i, state_dbg, ctl, st[i], ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sw_timeout();
    logic [3:0]  st [14];
    logic [18:0] ex [14];
    logic        rd [14];
    st = '{ST_F, ST_D, ST_MA, ST_MW, ST_MW, ST_MW, ST_MW,
           ST_F, ST_D, ST_MA, ST_MW, ST_MW, ST_MW, ST_MW};
    ex = '{E_FR, E_DEC, E_MA, E_WW, E_WW, E_WW, E_WTO,
           E_FR, E_DEC, E_MA, E_WW, E_WW, E_WW, E_WR};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Opcode = 6'b101011;
    for (int i = 0; i < 14; i++) begin
      mem_ready = rd[i];
      #1;
      total++;
      if (state_dbg !== st[i] || ctl !== ex[i]) begin
        bad++;
        $display("FAIL sw_to[%0d]: state=%0d ctl=%05h want %0d/%05h",
                 i, state_dbg, ctl, st[i], ex[i]);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (state_dbg !== ST_F) begin
      bad++;
      $display("FAIL sw_ready_return: state=%0d want %0d",
               state_dbg, ST_F);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  st [5];
    logic [18:0] ex [5];
    logic        rd [5];
    st = '{ST_F, ST_D, ST_MA, ST_MW, ST_MW};
    ex = '{E_FR, E_DEC, E_MA, E_WW, E_WW};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    Opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #1;
      total++;
      if (state_dbg !== st[i] || ctl !== ex[i]) begin
        bad++;
        $display("FAIL rst_mid[%0d]: state=%0d ctl=%05h want %0d/%05h",
                 i, state_dbg, ctl, st[i], ex[i]);
      end
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    total++;
    if (state_dbg !== ST_I || ctl !== 19'd0) begin
      bad++;
      $display("FAIL rst_mid_async: state=%0d ctl=%05h want 0/00000",
               state_dbg, ctl);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (state_dbg !== ST_I || ctl !== 19'd0) begin
      bad++;
      $display("FAIL rst_mid_idle: state=%0d ctl=%05h want 0/00000",
               state_dbg, ctl);
    end
    @(posedge clk);
    #1;
    total++;
    if (state_dbg !== ST_F || ctl !== E_FW) begin
      bad++;
      $display("FAIL rst_mid_fetch: state=%0d ctl=%05h want %0d/%05h",
               state_dbg, ctl, ST_F, E_FW);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_jr();
    test_back_to_back();
    test_illegal();
    test_fetch_timeout();
    test_sw_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
